mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the data-access requester that the request unit drives.
- Serialises transactions with fixed priority: data first, instruction second.
- Holds address, data and strobes stable until the memory acknowledges, then returns a ready strobe and the load data to the winning requester.
- A watchdog aborts any transaction the memory never acknowledges.

Parameters:
- TIMEOUT, 16: maximum cycles a transaction waits for mem_ack before it is aborted (must be >= 2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imemRen  in  1  instruction read request.
- imemaddr  in  ADDR_W  instruction address.
- imemload  out  DATA_W  instruction read data.
- i_ready  out  1  instruction transaction complete.
- dmmRen  in  1  data read request.
- dmmWen  in  1  data write request.
- dmmaddr  in  ADDR_W  data address.
- dmmstore  in  DATA_W  data to write.
- dmmload  out  DATA_W  data read data.
- d_ready  out  1  data transaction complete.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion, one cycle.
- err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY. Reset state is IDLE.
- Values held in reset: mem_ren/mem_wen/mem_addr/mem_wdata = 0, imemload/dmmload = 0, i_ready/d_ready/err = 0, watchdog counter = 0.
- Reset mid-transaction: the transaction is dropped with no ready pulse; the next transaction starts only after RST falls.
- IDLE:
  - On a rising edge with (dmmRen | dmmWen), latch dmmaddr, dmmstore and the write flag, then go to DBUSY.
  - Otherwise, if imemRen, latch imemaddr and go to IBUSY.
  - When data and instruction requests arrive in the same cycle, data wins; the instruction request is served after the data transaction completes.
- Write flag: dmmWen=1 means write; otherwise read. If dmmRen and dmmWen are both 1, the write wins.
- Memory drive in BUSY states:
  - mem_ren = 1 in IBUSY, and in DBUSY for a read.
  - mem_wen = 1 in DBUSY for a write.
  - mem_addr and mem_wdata come from the latched registers; mem_wdata = 0 for reads.
  - Outputs stay stable for the whole transaction even if the requester changes its inputs.
  - All mem_* outputs are 0 in IDLE.
- Completion:
  - i_ready = (state==IBUSY) & mem_ack and d_ready = (state==DBUSY) & mem_ack. Both are combinational, so the requester sees ready on the same edge the FSM returns to IDLE.
  - In the ack cycle, imemload/dmmload pass mem_rdata through combinationally. At that edge mem_rdata is registered and held until the next completion of the same requester.
  - A data write updates nothing in dmmload.
- Minimum latency: request edge, then 1 BUSY cycle with ack, then IDLE. Back-to-back transactions therefore take at least 2 cycles each.
- Request withdrawn mid-transaction: the transaction still completes and ready still pulses.
- Watchdog:
  - The counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the counter equals TIMEOUT-1 and mem_ack=0, the transaction aborts: ready pulses for the owner, err=1 for that cycle, the owner's load output gives 0 for that cycle, the held register is cleared to 0, and the FSM goes to IDLE.
  - If ack arrives in the same cycle as the timeout, the ack wins and err stays 0.
- mem_ack in IDLE is ignored.

Test Plan:
- Reset behaviour: hold RST=1 with requests active → all outputs 0. Release RST with imemRen=1, imemaddr=32'h12341234 → next cycle mem_ren=1 and mem_addr=32'h12341234.
- Instruction read: memory acks 3 cycles later with mem_rdata=32'h00A00093 → i_ready=1 that cycle and imemload=32'h00A00093, which holds after return to IDLE.
- Priority: imemRen=1 and dmmRen=1 (dmmaddr=32'h00010001) in the same cycle → data is served first with d_ready; the instruction is served next with i_ready. Both complete.
- Data write: dmmWen=1, dmmaddr=32'h01010101, dmmstore=32'hABCDABCD; change dmmstore to 32'hDACBDACB mid-transaction → mem_wdata stays 32'hABCDABCD until ack, and dmmload is unchanged.
- Timeout: DBUSY read with no ack and TIMEOUT=16 → on the 16th BUSY cycle d_ready=1, err=1, dmmload=0; the FSM is in IDLE the next cycle. In a separate run, ack in that same cycle → err=0.
- Reset mid-transaction: assert RST asynchronously while in IBUSY → mem_ren drops immediately, and no i_ready pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester fixed-priority arbiter for a single-port memory
// Data requests beat instruction requests; a watchdog aborts unacknowledged transactions.
module mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemRen,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              i_ready,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [ADDR_W-1:0] dmmaddr,
  input  logic [DATA_W-1:0] dmmstore,
  output logic [DATA_W-1:0] dmmload,
  output logic              d_ready,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t            state_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;
  logic              mem_ren_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic busy;
  logic ack_cyc;
  logic tmo;
  logic done;

  assign busy    = (state_q != IDLE);
  assign ack_cyc = busy & mem_ack;
  // An ack arriving on the last allowed cycle takes precedence over the abort.
  assign tmo     = busy & ~mem_ack & (cnt_q == CNT_LAST);
  assign done    = ack_cyc | tmo;

  assign i_ready = (state_q == IBUSY) & done;
  assign d_ready = (state_q == DBUSY) & done;
  assign err     = tmo;

  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    imemload = iload_q;
    if (state_q == IBUSY) begin
      if (mem_ack)  imemload = mem_rdata;
      else if (tmo) imemload = '0;
    end
  end

  always_comb begin
    dmmload = dload_q;
    if (state_q == DBUSY) begin
      if (mem_ack && !wr_q) dmmload = mem_rdata;
      else if (tmo)         dmmload = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (dmmRen || dmmWen) begin
            state_q     <= DBUSY;
            wr_q        <= dmmWen;
            mem_ren_q   <= ~dmmWen;
            mem_wen_q   <= dmmWen;
            mem_addr_q  <= dmmaddr;
            mem_wdata_q <= dmmWen ? dmmstore : '0;
          end else if (imemRen) begin
            state_q     <= IBUSY;
            wr_q        <= 1'b0;
            mem_ren_q   <= 1'b1;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= imemaddr;
            mem_wdata_q <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (done) begin
            // Held load registers capture the pass-through value seen this cycle.
            if (state_q == IBUSY) iload_q <= imemload;
            else                  dload_q <= dmmload;
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
// Stimulus pushes expected completions; a responder and a monitor check the bus and the requesters.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imemRen = 1'b0;
  logic [31:0] imemaddr = '0;
  logic [31:0] imemload;
  logic        i_ready;
  logic        dmmRen = 1'b0;
  logic        dmmWen = 1'b0;
  logic [31:0] dmmaddr = '0;
  logic [31:0] dmmstore = '0;
  logic [31:0] dmmload;
  logic        d_ready;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  mem_arbiter #(.TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .imemRen(imemRen), .imemaddr(imemaddr), .imemload(imemload), .i_ready(i_ready),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .dmmload(dmmload), .d_ready(d_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } plan_t;

  typedef struct {
    bit          is_d;
    logic [31:0] load;
    bit          err;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          i_cnt = 0;
  int          d_cnt = 0;
  bit          exp_done_now = 1'b0;
  logic [31:0] held_i = '0;
  logic [31:0] held_d = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Reference: a transaction acked within TO busy cycles returns its read data
  // (writes leave the data load untouched); otherwise it aborts with err and load 0.
  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    plan_t p;
    exp_t  e;
    p.is_d = is_d; p.we = we; p.addr = addr; p.wdata = wdata; p.rdata = rdata; p.delay = delay;
    plan_q.push_back(p);
    e.is_d = is_d;
    if (delay <= TO) begin
      e.err  = 1'b0;
      e.load = (is_d && we) ? held_d : rdata;
    end else begin
      e.err  = 1'b1;
      e.load = '0;
    end
    if (is_d) held_d = e.load;
    else      held_i = e.load;
    exp_q.push_back(e);
  endtask

  // Memory responder: acks on the planned busy cycle and checks the bus is stable.
  initial begin : responder
    bit    busy;
    bit    post;
    int    n;
    plan_t cur;
    busy = 1'b0; post = 1'b0; n = 0;
    forever begin
      @(posedge CLK); #1;
      mem_ack = 1'b0;
      exp_done_now = 1'b0;
      mem_rdata = $urandom;
      if (RST) begin
        busy = 1'b0;
        post = 1'b0;
      end else begin
        if (post) begin
          post = 1'b0;
          chk("idle_after_done", {mem_ren, mem_wen}, 2'b00);
        end else if (!busy) begin
          if (mem_ren || mem_wen) begin
            if (plan_q.size() == 0) fail("unexpected_start");
            else begin
              cur  = plan_q.pop_front();
              busy = 1'b1;
              n    = 0;
            end
          end else begin
            chk("idle_bus", {mem_addr, mem_wdata}, 64'h0);
            if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
          end
        end
        if (busy) begin
          n++;
          chk("strobes", {mem_ren, mem_wen}, {!(cur.is_d && cur.we), cur.is_d && cur.we});
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", mem_wdata, cur.we ? cur.wdata : 32'h0);
          if (n == cur.delay) begin
            mem_ack = 1'b1;
            mem_rdata = cur.rdata;
            exp_done_now = 1'b1;
            busy = 1'b0;
            post = 1'b1;
          end else if (n == TO) begin
            exp_done_now = 1'b1;
            busy = 1'b0;
            post = 1'b1;
          end
        end
      end
    end
  end

  // Requester-side monitor: pops the scoreboard on every ready pulse.
  initial begin : monitor
    exp_t        e;
    logic [31:0] last_i;
    logic [31:0] last_d;
    last_i = '0; last_d = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("reset_outputs", {i_ready, d_ready, err, mem_ren, mem_wen, imemload, dmmload,
                              mem_addr, mem_wdata}, 160'h0);
        last_i = '0;
        last_d = '0;
      end else begin
        chk("ready_timing", i_ready | d_ready, exp_done_now);
        if (i_ready || d_ready) begin
          if (exp_q.size() == 0) fail("unexpected_ready");
          else begin
            e = exp_q.pop_front();
            chk("owner", {i_ready, d_ready}, e.is_d ? 2'b01 : 2'b10);
            chk("err", err, e.err);
            if (e.is_d) begin
              chk("dmmload", dmmload, e.load);
              chk("imemload_held", imemload, last_i);
              last_d = e.load;
              d_cnt++;
            end else begin
              chk("imemload", imemload, e.load);
              chk("dmmload_held", dmmload, last_d);
              last_i = e.load;
              i_cnt++;
            end
          end
        end else begin
          chk("err_idle", err, 1'b0);
          chk("imemload_held", imemload, last_i);
          chk("dmmload_held", dmmload, last_d);
        end
      end
    end
  end

  task automatic round(input bit do_i, input bit do_d, input bit we, input bit rw_both,
                       input bit hold, input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] dw, input int idel, input int ddel);
    int i0;
    int d0;
    int cyc;
    i0 = i_cnt; d0 = d_cnt; cyc = 0;
    @(posedge CLK); #1;
    if (do_d) begin
      dmmWen = we;
      dmmRen = !we || rw_both;
      dmmaddr = da;
      dmmstore = dw;
      issue(1'b1, we, da, dw, $urandom, ddel);
    end
    if (do_i) begin
      imemRen = 1'b1;
      imemaddr = ia;
      issue(1'b0, 1'b0, ia, 32'h0, $urandom, idel);
    end
    do begin
      @(posedge CLK); #1;
      cyc++;
      if (do_d && (!hold || d_cnt != d0)) begin
        dmmRen = 1'b0;
        dmmWen = 1'b0;
      end
      if (do_d) begin
        dmmaddr = $urandom;
        dmmstore = $urandom;
      end
      if (do_i && !do_d) begin
        imemaddr = $urandom;
        if (!hold) imemRen = 1'b0;
      end
      if (do_i && i_cnt != i0) imemRen = 1'b0;
    end while (((do_i && i_cnt == i0) || (do_d && d_cnt == d0)) && cyc < 100);
    if (cyc >= 100) fail("round_timeout");
    imemRen = 1'b0;
    dmmRen = 1'b0;
    dmmWen = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge CLK);
  endtask

  task automatic reset_mid;
    plan_t p;
    @(posedge CLK); #1;
    imemRen = 1'b1;
    imemaddr = $urandom;
    p.is_d = 1'b0; p.we = 1'b0; p.addr = imemaddr; p.wdata = '0; p.rdata = '0; p.delay = TO + 5;
    plan_q.push_back(p);
    @(posedge CLK); #1;
    imemRen = 1'b0;
    @(posedge CLK); #2;
    chk("busy_before_reset", mem_ren, 1'b1);
    #1 RST = 1'b1;
    #1 chk("reset_async_ren", {mem_ren, i_ready}, 2'b00);
    plan_q.delete();
    held_i = '0;
    held_d = '0;
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  initial begin : stimulus
    int cyc;
    int kind;
    bit w;
    bit h;
    #1 RST = 1'b1;
    imemRen = 1'b1;
    dmmRen = 1'b1;
    dmmaddr = 32'h00010001;
    repeat (3) @(posedge CLK);
    #1;
    dmmRen = 1'b0;
    imemaddr = 32'h12341234;
    issue(1'b0, 1'b0, 32'h12341234, 32'h0, 32'h00A00093, 3);
    @(negedge CLK); #2 RST = 1'b0;
    @(posedge CLK); #1;
    chk("first_req", {mem_ren, mem_wen, mem_addr}, {1'b1, 1'b0, 32'h12341234});
    imemRen = 1'b0;
    cyc = 0;
    while (i_cnt == 0 && cyc < 50) begin
      @(posedge CLK);
      cyc++;
    end
    if (cyc >= 50) fail("first_txn_timeout");
    repeat (3) @(posedge CLK);

    round(1, 1, 0, 0, 1, $urandom, 32'h00010001, 32'h0, 2, 4);
    round(0, 1, 1, 0, 1, 32'h0, 32'h01010101, 32'hABCDABCD, 0, 5);
    round(0, 1, 1, 1, 0, 32'h0, 32'h0000_0040, 32'h5555AAAA, 0, 1);
    round(0, 1, 0, 0, 1, 32'h0, 32'h0000_0080, 32'h0, 0, TO + 1);
    round(0, 1, 0, 0, 1, 32'h0, 32'h0000_0084, 32'h0, 0, TO);
    round(1, 0, 0, 0, 0, 32'h0000_0100, 32'h0, 32'h0, TO + 2, 0);
    round(1, 0, 0, 0, 1, 32'h0000_0104, 32'h0, 32'h0, 1, 0);
    reset_mid();
    round(1, 0, 0, 0, 1, 32'h0000_0200, 32'h0, 32'h0, 2, 0);

    for (int r = 0; r < 80; r++) begin
      kind = $urandom_range(0, 2);
      w = $urandom_range(0, 1);
      h = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      round(kind != 1, kind != 0, w, 1'($urandom_range(0, 1)), h, $urandom, $urandom, $urandom,
            $urandom_range(1, TO + 2), w ? $urandom_range(1, TO) : $urandom_range(1, TO + 2));
    end

    repeat (4) @(posedge CLK);
    if (exp_q.size() != 0) fail("leftover_expected");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
